// File: rtl/led_blink_pkg.sv
// rtl/led_blink_pkg.sv - shared mode encoding and widths for the LED pattern generator
package led_blink_pkg;

  localparam int MODE_W = 2;
  localparam int PWM_W  = 4;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

endpackage

// File: rtl/led_blink_ch.sv
// rtl/led_blink_ch.sv - one LED channel: mode, half-period, tick counter and lit flag
module led_blink_ch
  import led_blink_pkg::*;
#(
  parameter int PER_W    = 16,
  parameter int DEF_HALF = 500
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             cfg_we_i,
  input  mode_e            cfg_mode_i,
  input  logic [PER_W-1:0] cfg_half_i,
  output logic             lit_o
);

  localparam logic [PER_W-1:0] ONE = PER_W'(1);

  mode_e            mode_q, mode_d;
  logic [PER_W-1:0] half_q, half_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic             lit_q, lit_d;
  logic             at_end;

  // half_q is never 0, so half_q-1 cannot underflow
  assign at_end = (cnt_q >= half_q - ONE);

  always_comb begin
    mode_d = mode_q;
    half_d = half_q;
    cnt_d  = cnt_q;
    lit_d  = lit_q;
    if (cfg_we_i) begin
      // a config on a tick cycle swallows that tick for this channel
      mode_d = cfg_mode_i;
      half_d = (cfg_half_i == '0) ? ONE : cfg_half_i;
      cnt_d  = '0;
      lit_d  = (cfg_mode_i != MODE_OFF);
    end else begin
      unique case (mode_q)
        MODE_BLINK: begin
          if (tick_i) begin
            if (at_end) begin
              cnt_d = '0;
              lit_d = ~lit_q;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end
        end
        MODE_ONESHOT: begin
          if (tick_i) begin
            if (at_end) begin
              mode_d = MODE_OFF;
              cnt_d  = '0;
              lit_d  = 1'b0;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end
        end
        MODE_ON: begin
          cnt_d = '0;
          lit_d = 1'b1;
        end
        default: begin
          cnt_d = '0;
          lit_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= MODE_OFF;
      half_q <= PER_W'(DEF_HALF);
      cnt_q  <= '0;
      lit_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      half_q <= half_d;
      cnt_q  <= cnt_d;
      lit_q  <= lit_d;
    end
  end

  assign lit_o = lit_q;

endmodule

// File: rtl/led_blink_multi.sv
// rtl/led_blink_multi.sv - multi-channel LED pattern generator with shared prescaler
// Optional LED_BLINK_PWM_EN adds a global 4-bit PWM duty gate on lit channels.
module led_blink_multi
  import led_blink_pkg::*;
#(
  parameter int CLK_HZ         = 25_000_000,
  parameter int TICK_HZ        = 1_000,
  parameter int N_CH           = 3,
  parameter int PER_W          = 16,
  parameter int DEF_HALF       = 500,
  parameter int LED_ACTIVE_LOW = 1,
  localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [MODE_W-1:0] cfg_mode_i,
  input  logic [PER_W-1:0]  cfg_half_i,
  output logic              cfg_err_o,
  output logic              tick_o,
`ifdef LED_BLINK_PWM_EN
  input  logic [PWM_W-1:0]  pwm_duty_i,
`endif
  output logic [N_CH-1:0]   led_o
);

  localparam int               DIV      = CLK_HZ / TICK_HZ;
  localparam int               PRE_W    = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             accept;
  logic             ch_ok;
  logic             pwm_on;
  logic [N_CH-1:0]  lit;
  logic [N_CH-1:0]  lit_gated;

  assign accept = cfg_valid_i & ready_q;
  assign ch_ok  = ({1'b0, cfg_ch_i} < (CH_W + 1)'(N_CH));

  // tick_q is high in the cycle after the prescaler wraps to 0
  always_comb begin
    pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
    tick_d  = (pre_q == PRE_LAST);
    ready_d = 1'b1;
    err_d   = accept & ~ch_ok;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    led_blink_ch #(
      .PER_W    (PER_W),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .tick_i     (tick_q),
      .cfg_we_i   (accept && ch_ok && (cfg_ch_i == CH_W'(g))),
      .cfg_mode_i (mode_e'(cfg_mode_i)),
      .cfg_half_i (cfg_half_i),
      .lit_o      (lit[g])
    );
  end

`ifdef LED_BLINK_PWM_EN
  logic [PWM_W-1:0] p_q, p_d;

  always_comb begin
    p_d = p_q + PWM_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign pwm_on = (p_q < pwm_duty_i);
`else
  assign pwm_on = 1'b1;
`endif

  assign lit_gated   = lit & {N_CH{pwm_on}};
  assign led_o       = (LED_ACTIVE_LOW != 0) ? ~lit_gated : lit_gated;
  assign tick_o      = tick_q;
  assign cfg_ready_o = ready_q;
  assign cfg_err_o   = err_q;

endmodule

// File: tb/tb_led_blink_multi.sv
// tb/tb_led_blink_multi.sv - scoreboard bench for led_blink_multi (tick every 2 clocks, 3 channels)
module tb_led_blink_multi;

  localparam int N_CH = 3;

  logic        clk_i       = 1'b0;
  logic        rst_ni      = 1'b0;
  logic        cfg_valid_i = 1'b0;
  logic [1:0]  cfg_ch_i    = '0;
  logic [1:0]  cfg_mode_i  = '0;
  logic [15:0] cfg_half_i  = '0;
  logic        cfg_ready_o;
  logic        cfg_err_o;
  logic        tick_o;
  logic [2:0]  led_o;
`ifdef LED_BLINK_PWM_EN
  logic [3:0]  pwm_duty_i  = 4'd4;
`endif

  int errors = 0;
  int checks = 0;
  int edges  = 0;
  int ch_mode [N_CH];
  int ch_half [N_CH];
  int ch_e    [N_CH];
  logic [2:0] exp_q [$];
  logic       err_seen;

  always #5 clk_i = ~clk_i;

  // posedges since reset release; ticks are consumed on odd edges >= 3
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) edges = 0;
    else         edges = edges + 1;
  end

  led_blink_multi #(
    .CLK_HZ         (10),
    .TICK_HZ        (5),
    .N_CH           (N_CH),
    .PER_W          (16),
    .DEF_HALF       (2),
    .LED_ACTIVE_LOW (1)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_ch_i    (cfg_ch_i),
    .cfg_mode_i  (cfg_mode_i),
    .cfg_half_i  (cfg_half_i),
    .cfg_err_o   (cfg_err_o),
    .tick_o      (tick_o),
`ifdef LED_BLINK_PWM_EN
    .pwm_duty_i  (pwm_duty_i),
`endif
    .led_o       (led_o)
  );

  function automatic logic [2:0] exp_led(int e);
    logic [2:0] r;
    int t;
    bit lit;
    for (int i = 0; i < N_CH; i++) begin
      t = (e + 1) / 2 - (ch_e[i] + 1) / 2;
      case (ch_mode[i])
        1:       lit = 1'b1;
        2:       lit = ((t / ch_half[i]) % 2) == 0;
        3:       lit = (t < ch_half[i]);
        default: lit = 1'b0;
      endcase
      r[i] = ~lit;
    end
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N_CH; i++) begin
      ch_mode[i] = 0;
      ch_half[i] = 2;
      ch_e[i]    = 0;
    end
    exp_q.delete();
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic cfg_send(input int ch, input int mode, input int half);
    cfg_valid_i = 1'b1;
    cfg_ch_i    = ch[1:0];
    cfg_mode_i  = mode[1:0];
    cfg_half_i  = half[15:0];
    @(posedge clk_i);
    #1;
    if (ch < N_CH) begin
      ch_mode[ch] = mode;
      ch_half[ch] = (half == 0) ? 1 : half;
      ch_e[ch]    = edges;
    end
    @(negedge clk_i);
    err_seen    = cfg_err_o;
    cfg_valid_i = 1'b0;
  endtask

  task automatic run_check(input string name, input int n);
    logic [2:0] exp;
    for (int k = 0; k < n; k++) exp_q.push_back(exp_led(edges + k));
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk_i);
      exp = exp_q.pop_front();
      checks++;
      if (led_o !== exp) begin
        errors++;
        $display("FAIL %s edge=%0d led_o=%b expected=%b", name, edges, led_o, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_model();
    repeat (5) begin
      @(negedge clk_i);
      checks++;
      if (led_o !== 3'b111) begin errors++; $display("FAIL reset_led led_o=%b expected=111", led_o); end
      checks++;
      if (tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick tick_o=%b expected=0", tick_o); end
      checks++;
      if (cfg_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready ready=%b expected=0", cfg_ready_o); end
      checks++;
      if (cfg_err_o !== 1'b0) begin errors++; $display("FAIL reset_err err=%b expected=0", cfg_err_o); end
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_release ready=%b expected=1", cfg_ready_o); end
  endtask

  task automatic test_tick();
    logic exp;
    repeat (10) begin
      @(negedge clk_i);
      exp = (edges >= 2) && (edges % 2 == 0);
      checks++;
      if (tick_o !== exp) begin errors++; $display("FAIL tick edge=%0d tick_o=%b expected=%b", edges, tick_o, exp); end
    end
  endtask

  task automatic test_blink();
    cfg_send(0, 2, 3);
    run_check("blink_h3", 26);
  endtask

  task automatic test_oneshot();
    cfg_send(1, 3, 2);
    run_check("oneshot_h2", 56);
  endtask

  task automatic test_half_zero();
    cfg_send(2, 2, 0);
    run_check("blink_h0", 12);
  endtask

  task automatic test_bad_channel();
    cfg_send(3, 1, 5);
    checks++;
    if (err_seen !== 1'b1) begin errors++; $display("FAIL badch_err_pulse err=%b expected=1", err_seen); end
    run_check("badch_led", 1);
    @(negedge clk_i);
    checks++;
    if (cfg_err_o !== 1'b0) begin errors++; $display("FAIL badch_err_clear err=%b expected=0", cfg_err_o); end
    run_check("badch_led_after", 6);
  endtask

  task automatic test_tick_collision();
    while (edges % 2 != 0) @(negedge clk_i);
    cfg_send(0, 2, 3);
    run_check("cfg_on_tick", 14);
    while (edges % 2 == 0) @(negedge clk_i);
    cfg_send(0, 2, 3);
    run_check("cfg_off_tick", 14);
  endtask

  task automatic test_oneshot_restart();
    cfg_send(1, 3, 3);
    repeat (3) @(negedge clk_i);
    cfg_send(1, 3, 3);
    run_check("oneshot_restart", 20);
  endtask

  task automatic test_async_reset();
    cfg_send(0, 2, 3);
    repeat (4) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (led_o !== 3'b111) begin errors++; $display("FAIL async_reset_led led_o=%b expected=111", led_o); end
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    clear_model();
    run_check("post_reset_idle", 12);
  endtask

`ifdef LED_BLINK_PWM_EN
  task automatic test_pwm();
    int low_cnt;
    cfg_send(0, 1, 1);
    repeat (2) begin
      low_cnt = 0;
      repeat (16) begin
        @(negedge clk_i);
        if (led_o[0] === 1'b0) low_cnt++;
      end
      checks++;
      if (low_cnt != 4) begin errors++; $display("FAIL pwm_duty4 low=%0d expected=4", low_cnt); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tick();
    test_blink();
    test_oneshot();
    test_half_zero();
    test_bad_channel();
    test_tick_collision();
    test_oneshot_restart();
    test_async_reset();
`ifdef LED_BLINK_PWM_EN
    test_pwm();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
